// File: rtl/l2_line_burst_responder_if.sv
// Bundle between the L1 arbiter and memory on one side and the L2 line burst responder on the other.
// The slave modport is the responder; the master modport is the requester/memory side.
interface l2_line_burst_responder_if #(
   parameter int LINE_BITS = 256,
   parameter int BEAT_BITS = 64,
   parameter int ADDR_BITS = 32
);
   localparam int REQ_BITS = ADDR_BITS + 2 + LINE_BITS;

   logic [REQ_BITS-1:0]  req_i;
   logic [LINE_BITS:0]   fb_o;
   logic [ADDR_BITS-1:0] address_o;
   logic                 read_o;
   logic                 write_o;
   logic [BEAT_BITS-1:0] burst_o;
   logic [BEAT_BITS-1:0] burst_i;
   logic                 resp_i;

   modport slave (
      input  req_i, burst_i, resp_i,
      output fb_o, address_o, read_o, write_o, burst_o
   );

   modport master (
      output req_i, burst_i, resp_i,
      input  fb_o, address_o, read_o, write_o, burst_o
   );
endinterface

// File: rtl/l2_line_burst_responder.sv
// Accepts one cacheline request at a time and turns it into a BEATS-beat memory burst,
// returning the assembled read line or a write acknowledge as a one-cycle mem_resp.
module l2_line_burst_responder #(
   parameter int LINE_BITS = 256,
   parameter int BEAT_BITS = 64,
   parameter int ADDR_BITS = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   l2_line_burst_responder_if.slave  bus
);
   localparam int BEATS      = LINE_BITS / BEAT_BITS;
   localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LINE_ALIGN = $clog2(LINE_BITS / 8);
   localparam int REQ_BITS   = ADDR_BITS + 2 + LINE_BITS;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CNT_W-1:0]     count;
   logic                 idle_hold;
   logic [ADDR_BITS-1:0] address;
   logic [LINE_BITS-1:0] line;
   logic [LINE_BITS-1:0] line_fill;
   logic [LINE_BITS-1:0] rdata;
   int                   beat_base;

   logic [ADDR_BITS-1:0] mem_addr;
   logic                 mem_read;
   logic                 mem_write;
   logic [LINE_BITS-1:0] mem_wdata;
   logic                 unused_addr_bits;

   logic                 accept;
   logic                 beat_take;
   logic                 last_take;

   assign mem_addr         = bus.req_i[REQ_BITS-1 -: ADDR_BITS];
   assign mem_read         = bus.req_i[LINE_BITS+1];
   assign mem_write        = bus.req_i[LINE_BITS];
   assign mem_wdata        = bus.req_i[LINE_BITS-1:0];
   assign unused_addr_bits = ^mem_addr[LINE_ALIGN-1:0];
   assign beat_base        = int'(count) * BEAT_BITS;

   // idle_hold blocks the first IDLE cycle after DONE so a still-held request is not re-accepted.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      beat_take = 1'b0;
      last_take = 1'b0;
      case (state)
         IDLE: begin
            if (!idle_hold && (mem_read || mem_write)) begin
               accept    = 1'b1;
               state_nxt = mem_write ? WRITE : READ;
            end
         end
         READ, WRITE: begin
            if (bus.resp_i) begin
               beat_take = 1'b1;
               if (count == LAST_BEAT) begin
                  last_take = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      line_fill = line;
      line_fill[beat_base +: BEAT_BITS] = bus.burst_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         idle_hold <= 1'b0;
      end else begin
         state     <= state_nxt;
         idle_hold <= (state == DONE);
         if (accept) begin
            count <= '0;
         end else if (beat_take) begin
            count <= count + 1'b1;
         end
      end
   end

   // rdata only changes when a read burst completes, so it survives writes and partial reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         address <= '0;
         line    <= '0;
         rdata   <= '0;
      end else begin
         if (accept) begin
            address <= {mem_addr[ADDR_BITS-1:LINE_ALIGN], {LINE_ALIGN{1'b0}}};
            if (mem_write) begin
               line <= mem_wdata;
            end
         end
         if (beat_take && (state == READ)) begin
            line <= line_fill;
         end
         if (last_take && (state == READ)) begin
            rdata <= line_fill;
         end
      end
   end

   assign bus.address_o = address;
   assign bus.read_o    = (state == READ);
   assign bus.write_o   = (state == WRITE);
   assign bus.burst_o   = (state == WRITE) ? line[beat_base +: BEAT_BITS] : '0;
   assign bus.fb_o      = {(state == DONE), rdata};
endmodule
